// File: rtl/game_state_tx.sv
// Game-state UART transmitter: snapshots the game state on send and sends a 7-byte packet LSB first.
// Optional even-parity bit per byte when GAME_TX_PARITY_EN is defined (default build: 8N1).
`timescale 1ns / 1ps

module game_state_tx #(
  parameter int unsigned CLKS_PER_BIT = 564,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        send,
  input  logic [11:0] ball_xpos,
  input  logic [11:0] ball_ypos,
  input  logic [3:0]  score_pl1,
  input  logic [3:0]  score_pl2,
  input  logic        endgame,
  input  logic        whistle,
  input  logic        last_touch,
  input  logic        mousectl,
  input  logic        reset_game,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun
);

  localparam int unsigned TimerW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [2:0]          bit_idx_q, bit_idx_d;
  logic [2:0]          byte_idx_q, byte_idx_d;
  logic [39:0]         snap_q, snap_d;
  logic                overrun_q, overrun_d;

  logic                bit_tick;
  logic [7:0]          checksum;
  logic [7:0]          cur_byte;

  assign bit_tick = (timer_q == TimerMax);
  assign checksum = snap_q[39:32] ^ snap_q[31:24] ^ snap_q[23:16] ^ snap_q[15:8] ^ snap_q[7:0];

  // Snapshot holds B1..B5; B0 and B6 are derived on the fly.
  always_comb begin
    cur_byte = checksum;
    case (byte_idx_q)
      3'd0:    cur_byte = SYNC_BYTE;
      3'd1:    cur_byte = snap_q[39:32];
      3'd2:    cur_byte = snap_q[31:24];
      3'd3:    cur_byte = snap_q[23:16];
      3'd4:    cur_byte = snap_q[15:8];
      3'd5:    cur_byte = snap_q[7:0];
      default: cur_byte = checksum;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      timer_q    <= '0;
      bit_idx_q  <= '0;
      byte_idx_q <= '0;
      snap_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      bit_idx_q  <= bit_idx_d;
      byte_idx_q <= byte_idx_d;
      snap_q     <= snap_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = '0;
    bit_idx_d  = bit_idx_q;
    byte_idx_d = byte_idx_q;
    snap_d     = snap_q;
    // Any send outside IDLE, including the DONE cycle, is dropped and flagged.
    overrun_d  = overrun_q | (send && (state_q != StIdle));

    if (state_q inside {StStart, StData, StParity, StStop}) begin
      timer_d = bit_tick ? '0 : timer_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if (send) begin
          state_d    = StStart;
          byte_idx_d = '0;
          bit_idx_d  = '0;
          snap_d     = {ball_xpos[11:8], ball_ypos[11:8], ball_xpos[7:0], ball_ypos[7:0],
                        score_pl1, score_pl2,
                        endgame, whistle, last_touch, mousectl, reset_game, 3'b000};
        end
      end
      StStart: begin
        if (bit_tick) begin
          state_d   = StData;
          bit_idx_d = '0;
        end
      end
      StData: begin
        if (bit_tick) begin
          if (bit_idx_q == 3'd7) begin
`ifdef GAME_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StParity: begin
        if (bit_tick) state_d = StStop;
      end
      StStop: begin
        if (bit_tick) begin
          if (byte_idx_q == 3'd6) begin
            state_d = StDone;
          end else begin
            byte_idx_d = byte_idx_q + 3'd1;
            state_d    = StStart;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    tx         = 1'b1;
    busy       = 1'b0;
    frame_done = 1'b0;
    overrun    = overrun_q;
    case (state_q)
      StStart: begin
        tx   = 1'b0;
        busy = 1'b1;
      end
      StData: begin
        tx   = cur_byte[bit_idx_q];
        busy = 1'b1;
      end
      StParity: begin
        tx   = ^cur_byte;
        busy = 1'b1;
      end
      StStop:  busy = 1'b1;
      StDone:  frame_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_game_state_tx.sv
// Randomized bench for game_state_tx: a packet-level model predicts every line bit and decoded byte.
`timescale 1ns / 1ps

module tb_game_state_tx;

  localparam int unsigned Cpb = 16;
`ifdef GAME_TX_PARITY_EN
  localparam int unsigned Bpb = 11;
`else
  localparam int unsigned Bpb = 10;
`endif
  localparam int unsigned NBits = 7 * Bpb;
  localparam int unsigned Total = NBits * Cpb;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        send = 1'b0;
  logic [11:0] x = '0;
  logic [11:0] y = '0;
  logic [3:0]  s1 = '0;
  logic [3:0]  s2 = '0;
  logic [4:0]  fl = '0;  // {endgame, whistle, last_touch, mousectl, reset_game}
  logic        tx, busy, frame_done, overrun;

  int n_vec = 0;
  int n_bad = 0;
  logic ovr_exp = 1'b0;

  always #5 clk = ~clk;

  game_state_tx #(
    .CLKS_PER_BIT(Cpb),
    .SYNC_BYTE   (8'hA5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .send      (send),
    .ball_xpos (x),
    .ball_ypos (y),
    .score_pl1 (s1),
    .score_pl2 (s2),
    .endgame   (fl[4]),
    .whistle   (fl[3]),
    .last_touch(fl[2]),
    .mousectl  (fl[1]),
    .reset_game(fl[0]),
    .tx        (tx),
    .busy      (busy),
    .frame_done(frame_done),
    .overrun   (overrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic randomize_inputs();
    x  = 12'($urandom_range(0, 4095));
    y  = 12'($urandom_range(0, 4095));
    s1 = 4'($urandom);
    s2 = 4'($urandom);
    fl = 5'($urandom);
  endtask

  // mode 0: plain, 1: inputs change during B2, 2: extra send during B3, 3: reset during B4 bit 3
  task automatic run_frame(input int mode);
    logic [7:0] pkt [7];
    logic [7:0] rx [7];
    logic       ebits [NBits];
    int         bad_busy, bad_fd, pos, k;

    @(negedge clk);
    check_eq("idle_tx", 32'(tx), 32'd1);
    check_eq("idle_busy", 32'(busy), 32'd0);

    pkt[0] = 8'hA5;
    pkt[1] = {x[11:8], y[11:8]};
    pkt[2] = x[7:0];
    pkt[3] = y[7:0];
    pkt[4] = {s1, s2};
    pkt[5] = {fl, 3'b000};
    pkt[6] = pkt[1] ^ pkt[2] ^ pkt[3] ^ pkt[4] ^ pkt[5];
    for (int b = 0; b < 7; b++) begin
      ebits[b*Bpb] = 1'b0;
      for (int i = 0; i < 8; i++) ebits[b*Bpb+1+i] = pkt[b][i];
`ifdef GAME_TX_PARITY_EN
      ebits[b*Bpb+9] = ^pkt[b];
`endif
      ebits[b*Bpb+Bpb-1] = 1'b1;
      rx[b] = '0;
    end

    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    bad_busy = 0;
    bad_fd   = 0;

    for (int j = 0; j <= int'(Total); j++) begin
      if (j > 0) @(negedge clk);
      if (j < int'(Total)) begin
        if (busy !== 1'b1) bad_busy++;
        if (frame_done !== 1'b0) bad_fd++;
        if (j == 0) check_eq("start_latency", 32'(tx), 32'd0);
        if (j % int'(Cpb) == int'(Cpb) / 2) begin
          pos = j / int'(Cpb);
          check_eq("tx_bit", 32'(tx), 32'(ebits[pos]));
          k = pos % int'(Bpb);
          if (k >= 1 && k <= 8) rx[pos/int'(Bpb)][k-1] = tx;
        end
        if (mode == 1 && j == int'((2 * Bpb + 3) * Cpb)) randomize_inputs();
        if (mode == 2 && j == int'((3 * Bpb + 3) * Cpb)) begin
          send    = 1'b1;
          ovr_exp = 1'b1;
        end
        if (mode == 2 && j == int'((3 * Bpb + 3) * Cpb) + 1) send = 1'b0;
        if (mode == 3 && j == int'((4 * Bpb + 4) * Cpb + Cpb / 2 + 1)) begin
          rst = 1'b0;
          #1;
          check_eq("rst_tx_async", 32'(tx), 32'd1);
          check_eq("rst_busy", 32'(busy), 32'd0);
          for (int r = 0; r < 3; r++) begin
            @(negedge clk);
            if (frame_done !== 1'b0) bad_fd++;
          end
          check_eq("rst_no_frame_done", 32'(bad_fd), 32'd0);
          check_eq("rst_overrun_clr", 32'(overrun), 32'd0);
          check_eq("busy_before_rst", 32'(bad_busy), 32'd0);
          rst     = 1'b1;
          ovr_exp = 1'b0;
          return;
        end
      end else begin
        check_eq("frame_done_at_end", 32'(frame_done), 32'd1);
        check_eq("busy_in_done", 32'(busy), 32'd0);
        check_eq("busy_gaps", 32'(bad_busy), 32'd0);
        check_eq("early_frame_done", 32'(bad_fd), 32'd0);
        for (int b = 0; b < 7; b++) check_eq($sformatf("byte%0d", b), 32'(rx[b]), 32'(pkt[b]));
        check_eq("overrun", 32'(overrun), 32'(ovr_exp));
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_eq("reset_tx", 32'(tx), 32'd1);
    check_eq("reset_busy", 32'(busy), 32'd0);
    check_eq("reset_frame_done", 32'(frame_done), 32'd0);
    check_eq("reset_overrun", 32'(overrun), 32'd0);
    rst = 1'b1;

    // Directed frame, then a snapshot-hold frame sent the cycle after frame_done.
    x = 12'h1A3; y = 12'h2B4; s1 = 4'd3; s2 = 4'd5; fl = 5'b10000;
    run_frame(0);
    run_frame(1);
    for (int i = 0; i < 4; i++) begin
      randomize_inputs();
      run_frame(0);
    end
    randomize_inputs();
    run_frame(2);
    randomize_inputs();
    run_frame(3);
    x = 12'h1A3; y = 12'h2B4; s1 = 4'd3; s2 = 4'd5; fl = 5'b10000;
    run_frame(0);
    randomize_inputs();
    run_frame(0);

    // send landing in the DONE cycle is dropped but flagged.
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    check_eq("done_send_busy", 32'(busy), 32'd0);
    check_eq("done_send_overrun", 32'(overrun), 32'd1);
    repeat (4) @(negedge clk);
    check_eq("done_send_tx_idle", 32'(tx), 32'd1);
    check_eq("done_send_still_idle", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
